// File: rtl/text_renderer_if.sv
// Character-buffer write port and font ROM lookup bundle for text_renderer.
// The master side owns the buffer writes and answers font lookups combinationally.
interface text_renderer_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned FX_W   = 2,
  parameter int unsigned FY_W   = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [13:0]       wr_data;
  logic [7:0]        font_char;
  logic [FX_W-1:0]   font_x;
  logic [FY_W-1:0]   font_y;
  logic              font_pixel;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output font_pixel,
    input  font_char,
    input  font_x,
    input  font_y
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  font_pixel,
    output font_char,
    output font_x,
    output font_y
  );
endinterface

// File: rtl/text_renderer.sv
// Three-stage text-mode pixel pipeline over a COLS x ROWS character buffer.
// Optional blinking reverse-video cursor is built when TEXT_CURSOR_EN is defined.
module text_renderer #(
  parameter int unsigned COLS     = 100,
  parameter int unsigned ROWS     = 37,
  parameter int unsigned GLYPH_W  = 4,
  parameter int unsigned GLYPH_H  = 8,
  parameter int unsigned ORIGIN_X = 0,
  parameter int unsigned ORIGIN_Y = 0,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 9,
  parameter int unsigned ADDR_W   = $clog2(COLS * ROWS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                display_on,
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      y,
  text_renderer_if.slave      bus,
  input  logic [6:0]          cur_col,
  input  logic [5:0]          cur_row,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic [2:0]          rgb
);

  localparam int unsigned Cells = COLS * ROWS;
  localparam int unsigned FxW   = $clog2(GLYPH_W);
  localparam int unsigned FyW   = $clog2(GLYPH_H);
  localparam int unsigned ColW  = X_W - FxW;
  localparam int unsigned RowW  = Y_W - FyW;

  // ---------------------------------------------------------------------------
  // Stage 1: window decode and buffer address
  // ---------------------------------------------------------------------------
  logic [X_W-1:0]    dx;
  logic [Y_W-1:0]    dy;
  logic [ColW-1:0]   cell_col;
  logic [RowW-1:0]   cell_row;
  logic              in_win;
  logic [ADDR_W-1:0] rd_addr;

  always_comb begin
    dx       = x - X_W'(ORIGIN_X);
    dy       = y - Y_W'(ORIGIN_Y);
    cell_col = dx[X_W-1:FxW];
    cell_row = dy[Y_W-1:FyW];
    in_win   = display_on
             && (32'(x) >= ORIGIN_X) && (32'(y) >= ORIGIN_Y)
             && (32'(cell_col) < COLS) && (32'(cell_row) < ROWS);
    // Park the read on cell 0 outside the window so the index is always legal.
    rd_addr  = '0;
    if (in_win) begin
      rd_addr = ADDR_W'(32'(cell_row) * COLS + 32'(cell_col));
    end
  end

  logic            win1_d, win1_q;
  logic [FxW-1:0]  gx1_d, gx1_q;
  logic [FyW-1:0]  gy1_d, gy1_q;

  always_comb begin
    win1_d = in_win;
    gx1_d  = dx[FxW-1:0];
    gy1_d  = dy[FyW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win1_q <= 1'b0;
      gx1_q  <= '0;
      gy1_q  <= '0;
    end else begin
      win1_q <= win1_d;
      gx1_q  <= gx1_d;
      gy1_q  <= gy1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Character buffer: one synchronous write port, one synchronous read port
  // ---------------------------------------------------------------------------
  logic [13:0] mem_q [Cells];
  logic [13:0] rd_word_q;
  logic        wr_ok;

  assign wr_ok = bus.wr_en && (32'(bus.wr_addr) < Cells);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // Contents persist through reset; only the write is blocked.
    end else if (wr_ok) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read-before-write: a same-address write lands after this sample.
  always_ff @(posedge clk) begin
    rd_word_q <= mem_q[rd_addr];
  end

  // ---------------------------------------------------------------------------
  // Optional cursor: frame counter and cell match
  // ---------------------------------------------------------------------------
  logic [2:0] hs_d, hs_q;
  logic [2:0] vs_d, vs_q;
  logic       swap;

`ifdef TEXT_CURSOR_EN
  logic [4:0]      frame_d, frame_q;
  logic [ColW-1:0] col1_q;
  logic [RowW-1:0] row1_q;

  always_comb begin
    frame_d = frame_q;
    if (vs_q[0] && !vs_q[1]) begin
      frame_d = frame_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q <= '0;
      col1_q  <= '0;
      row1_q  <= '0;
    end else begin
      frame_q <= frame_d;
      col1_q  <= cell_col;
      row1_q  <= cell_row;
    end
  end

  assign swap = frame_q[4] && (32'(col1_q) == 32'(cur_col)) && (32'(row1_q) == 32'(cur_row));
`else
  logic unused_cursor;
  assign unused_cursor = ^{cur_col, cur_row};
  assign swap          = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Stage 2: font lookup and colour select
  // ---------------------------------------------------------------------------
  logic [2:0] fg, bg;
  logic       win2_d, win2_q;
  logic       pix2_d, pix2_q;
  logic [2:0] fg2_d, fg2_q;
  logic [2:0] bg2_d, bg2_q;

  always_comb begin
    bus.font_char = rd_word_q[7:0];
    bus.font_x    = gx1_q;
    bus.font_y    = gy1_q;
    fg            = rd_word_q[10:8];
    bg            = rd_word_q[13:11];
    win2_d        = win1_q;
    pix2_d        = bus.font_pixel;
    fg2_d         = swap ? bg : fg;
    bg2_d         = swap ? fg : bg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win2_q <= 1'b0;
      pix2_q <= 1'b0;
      fg2_q  <= '0;
      bg2_q  <= '0;
    end else begin
      win2_q <= win2_d;
      pix2_q <= pix2_d;
      fg2_q  <= fg2_d;
      bg2_q  <= bg2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: pixel colour and matching sync delay
  // ---------------------------------------------------------------------------
  logic [2:0] rgb_d, rgb_q;

  always_comb begin
    rgb_d = 3'b000;
    if (win2_q) begin
      rgb_d = pix2_q ? fg2_q : bg2_q;
    end
    hs_d = {hs_q[1:0], hsync_in};
    vs_d = {vs_q[1:0], vsync_in};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= '0;
      hs_q  <= '0;
      vs_q  <= '0;
    end else begin
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign rgb       = rgb_q;
  assign hsync_out = hs_q[2];
  assign vsync_out = vs_q[2];

endmodule

// File: tb/tb_text_renderer.sv
// Randomised bench for text_renderer against a cell/glyph arithmetic reference model.
// Cursor expectations follow TEXT_CURSOR_EN when the bench is built with it.
module tb_text_renderer;

  localparam int Cols  = 100;
  localparam int Rows  = 37;
  localparam int GlW   = 4;
  localparam int GlH   = 8;
  localparam int OrgX  = 0;
  localparam int OrgY  = 0;
  localparam int Cells = Cols * Rows;

  typedef struct {
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       hsync_in, vsync_in, display_on;
  logic [9:0] x;
  logic [8:0] y;
  logic [6:0] cur_col;
  logic [5:0] cur_row;
  logic       hsync_out, vsync_out;
  logic [2:0] rgb;

  int         font_mode;  // 0: pattern ROM, 1: all ones, 2: all zeros
  int         n_checks;
  int         n_fail;
  logic [13:0] ref_mem [Cells];
  logic [4:0] frames;
  logic       vs_prev;
  exp_t       exp_q[$];

  text_renderer_if #(.ADDR_W(12), .FX_W(2), .FY_W(3)) bus ();

  text_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .display_on (display_on),
    .x          (x),
    .y          (y),
    .bus        (bus),
    .cur_col    (cur_col),
    .cur_row    (cur_row),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .rgb        (rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic font_fn(input logic [7:0] c, input int fx, input int fy);
    logic [7:0] cc;
    cc = c;
    return cc[(fx + fy) % 8];
  endfunction

  assign bus.font_pixel = (font_mode == 0) ? font_fn(bus.font_char, int'(bus.font_x),
                                                     int'(bus.font_y))
                                           : (font_mode == 1);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pixel clock: predict, update the model buffer, clock, compare.
  task automatic step();
    exp_t       e;
    exp_t       old;
    int         xi, yi, col, row, fx, fy;
    bit         win;
    logic [13:0] w;
    logic [2:0] fg, bg, tmp;
    logic       pix;
    xi  = int'(x) - OrgX;
    yi  = int'(y) - OrgY;
    win = display_on && (xi >= 0) && (yi >= 0) && (xi / GlW < Cols) && (yi / GlH < Rows);
    col = win ? xi / GlW : 0;
    row = win ? yi / GlH : 0;
    fx  = win ? xi % GlW : 0;
    fy  = win ? yi % GlH : 0;
    w   = ref_mem[row * Cols + col];
    fg  = w[10:8];
    bg  = w[13:11];
`ifdef TEXT_CURSOR_EN
    if (frames[4] && col == int'(cur_col) && row == int'(cur_row)) begin
      tmp = fg;
      fg  = bg;
      bg  = tmp;
    end
`endif
    pix   = (font_mode == 0) ? font_fn(w[7:0], fx, fy) : (font_mode == 1);
    e.rgb = win ? (pix ? fg : bg) : 3'b000;
    e.hs  = hsync_in;
    e.vs  = vsync_in;
    if (vsync_in && !vs_prev) frames = frames + 5'd1;
    vs_prev = vsync_in;
    if (bus.wr_en && int'(bus.wr_addr) < Cells) ref_mem[bus.wr_addr] = bus.wr_data;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (win) begin
      check_eq("font_char", 32'(bus.font_char), 32'(w[7:0]));
      check_eq("font_x", 32'(bus.font_x), 32'(fx));
      check_eq("font_y", 32'(bus.font_y), 32'(fy));
    end
    if (exp_q.size() == 3) begin
      old = exp_q.pop_front();
      check_eq("rgb", 32'(rgb), 32'(old.rgb));
      check_eq("hsync_out", 32'(hsync_out), 32'(old.hs));
      check_eq("vsync_out", 32'(vsync_out), 32'(old.vs));
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.wr_en  = 1'b0;
    display_on = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write_cell(input int addr, input logic [13:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 12'(addr);
    bus.wr_data = data;
    display_on  = 1'b0;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic scan(input int px, input int py, input int n);
    display_on = 1'b1;
    x          = 10'(px);
    y          = 9'(py);
    for (int i = 0; i < n; i++) step();
    display_on = 1'b0;
  endtask

  task automatic restart_pipe();
    exp_t z;
    z.rgb = 3'b000;
    z.hs  = 1'b0;
    z.vs  = 1'b0;
    exp_q.delete();
    exp_q.push_back(z);
    exp_q.push_back(z);
    frames  = 5'd0;
    vs_prev = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    font_mode   = 0;
    rst         = 1'b0;
    hsync_in    = 1'b0;
    vsync_in    = 1'b0;
    display_on  = 1'b0;
    x           = '0;
    y           = '0;
    cur_col     = 7'd2;
    cur_row     = 6'd3;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_rgb", 32'(rgb), 32'd0);
    check_eq("reset_hsync", 32'(hsync_out), 32'd0);
    check_eq("reset_vsync", 32'(vsync_out), 32'd0);
    rst = 1'b1;
    restart_pipe();

    // Fill the whole buffer so every cell has a known word.
    for (int a = 0; a < Cells; a++) write_cell(a, 14'($urandom));

    // Glyph 'A' in white at the top-left cell.
    font_mode = 1;
    write_cell(0, {3'b000, 3'b111, 8'h41});
    scan(0, 0, 1);
    idle(2);

    // Background-only pixel of cell (1,1).
    font_mode = 2;
    write_cell(101, {3'b100, 3'b010, 8'h20});
    scan(5, 9, 1);
    idle(2);

    // Right edge of the window and blanked display.
    font_mode = 0;
    hsync_in  = 1'b1;
    scan(400, 0, 1);
    hsync_in  = 1'b0;
    scan(399, 0, 1);
    hsync_in  = 1'b1;
    display_on = 1'b0;
    x = 10'd8;
    y = 9'd8;
    step();
    hsync_in = 1'b0;
    scan(0, 296, 1);
    scan(0, 295, 1);
    idle(2);

    // Out-of-range write, then same-cycle read/write of cell 5.
    write_cell(Cells, 14'h3fff);
    scan(Cols * GlW - 1, Rows * GlH - 1, 1);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 12'd5;
    bus.wr_data = ~ref_mem[5];
    scan(20, 0, 1);
    bus.wr_en   = 1'b0;
    scan(21, 1, 1);
    idle(2);

    // Random scanning with interleaved writes.
    for (int i = 0; i < 1500; i++) begin
      display_on  = ($urandom_range(0, 7) != 0);
      x           = 10'($urandom_range(0, 419));
      y           = 9'($urandom_range(0, 305));
      hsync_in    = 1'($urandom);
`ifdef TEXT_CURSOR_EN
      vsync_in    = 1'b0;
`else
      vsync_in    = 1'($urandom);
`endif
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_addr = 12'($urandom_range(0, Cells + 99));
      bus.wr_data = 14'($urandom);
      step();
    end
    bus.wr_en = 1'b0;
    hsync_in  = 1'b0;
    vsync_in  = 1'b0;
    idle(2);

    // Reset mid-line; a write during reset must not land.
    font_mode = 1;
    write_cell(200, {3'b111, 3'b111, 8'h00});
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    scan(0, 16, 4);
    display_on = 1'b1;
    rst = 1'b0;
    #1;
    check_eq("rst_rgb", 32'(rgb), 32'd0);
    check_eq("rst_hsync", 32'(hsync_out), 32'd0);
    check_eq("rst_vsync", 32'(vsync_out), 32'd0);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 12'd200;
    bus.wr_data = {3'b001, 3'b001, 8'h00};
    @(posedge clk);
    #1;
    check_eq("rst_hold_rgb", 32'(rgb), 32'd0);
    @(negedge clk);
    bus.wr_en = 1'b0;
    rst = 1'b1;
    restart_pipe();
    scan(0, 16, 5);
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    idle(2);

    // Cursor cell across 16 and 32 frame edges.
    write_cell(302, {3'b110, 3'b001, 8'h00});
    scan(8, 24, 1);
    idle(2);
    for (int i = 0; i < 16; i++) begin
      vsync_in = 1'b1;
      step();
      vsync_in = 1'b0;
      step();
    end
    idle(3);
    scan(9, 25, 1);
    scan(4, 24, 1);
    idle(2);
    for (int i = 0; i < 16; i++) begin
      vsync_in = 1'b1;
      step();
      vsync_in = 1'b0;
      step();
    end
    idle(3);
    scan(10, 31, 1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/text_renderer.md
TEXT_RENDERER -- requirements
Module: text_renderer

Interface
REQ-001 SHALL have parameter COLS, default 100, text columns.
REQ-002 SHALL have parameter ROWS, default 37, text rows.
REQ-003 SHALL have parameters GLYPH_W, default 4, and GLYPH_H, default 8, glyph size in pixels; each SHALL be a power of two.
REQ-004 SHALL have parameters ORIGIN_X, default 0, and ORIGIN_Y, default 0, top-left pixel of the text window.
REQ-005 SHALL have parameters X_W, default 10, and Y_W, default 9, pixel coordinate widths; ADDR_W SHALL equal clog2(COLS*ROWS).
REQ-006 Ports SHALL be:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-low
- hsync_in, vsync_in, display_on  in  1 each  timing from the sync generator
- x  in  X_W  screen column
- y  in  Y_W  screen row
- wr_en  in  1  character buffer write strobe
- wr_addr  in  ADDR_W  linear cell index, row*COLS+col
- wr_data  in  14  {bg[2:0], fg[2:0], char[7:0]}
- font_char  out  8  glyph select to the font ROM
- font_x  out  clog2(GLYPH_W)  glyph column
- font_y  out  clog2(GLYPH_H)  glyph row
- font_pixel  in  1  combinational font ROM result
- cur_col  in  7, cur_row  in  6  cursor cell
- hsync_out, vsync_out  out  1 each  delayed sync
- rgb  out  3  pixel colour {r,g,b}

Function
REQ-007 The block SHALL contain a COLS*ROWS x 14 character buffer with one synchronous write port and one synchronous read port.
REQ-008 A write SHALL occur on a clk edge with wr_en=1 and wr_addr<COLS*ROWS; writes with wr_addr>=COLS*ROWS SHALL be ignored.
REQ-009 When a read and a write hit the same address in the same cycle, the read SHALL return the old contents.
REQ-010 Stage 1: with dx=x-ORIGIN_X and dy=y-ORIGIN_Y, in_win SHALL be 1 when x>=ORIGIN_X, y>=ORIGIN_Y, dx/GLYPH_W<COLS, dy/GLYPH_H<ROWS and display_on=1; divisions SHALL be shifts.
REQ-011 Stage 1 SHALL issue a buffer read of (dy/GLYPH_H)*COLS+(dx/GLYPH_W); it SHALL register in_win, dx mod GLYPH_W, dy mod GLYPH_H and the cell column/row.
REQ-012 Stage 2 SHALL drive font_char from the read char and font_x/font_y from the registered glyph offsets; it SHALL sample font_pixel at the end of the stage.
REQ-013 Stage 3 SHALL register rgb = fg when font_pixel=1 and bg otherwise, while in_win=1; rgb SHALL be 0 when in_win=0.
REQ-014 Latency SHALL be 3 clk cycles from x/y/display_on to rgb.
REQ-015 hsync_out and vsync_out SHALL equal hsync_in and vsync_in delayed by exactly 3 cycles.
REQ-016 Font outputs SHALL be driven on every cycle; their value outside the window SHALL be don't-care.

Reset
REQ-017 rst=0 SHALL immediately force rgb, hsync_out, vsync_out and all pipeline valid/in_win flags to 0.
REQ-018 Character buffer contents SHALL NOT be reset; they SHALL persist across a reset.
REQ-019 A write presented while rst=0 SHALL be ignored.
REQ-020 After rst rises, the first 3 cycles SHALL output rgb=0.

Configuration
REQ-021 With TEXT_CURSOR_EN defined, the block SHALL keep a 5-bit frame counter that increments on each registered rising edge of vsync_in and resets to 0.
REQ-022 With TEXT_CURSOR_EN defined and counter bit 4=1, pixels of cell (cur_col, cur_row) SHALL show fg and bg swapped.
REQ-023 Without TEXT_CURSOR_EN, the block SHALL have no counter, cur_col and cur_row SHALL be ignored, and there SHALL be no swap.

Verification
REQ-024 Write addr 0 with {3'b000,3'b111,8'h41}, then scan x=0,y=0 with font_pixel=1 -> font_char=8'h41 and, 3 cycles later, rgb=3'b111.
REQ-025 Write addr 101 (col 1, row 1) with bg=3'b100, then x=5,y=9 with font_pixel=0 -> rgb=3'b100, font_x=1, font_y=1.
REQ-026 x=400 (column 100) or display_on=0 -> rgb=0 and hsync_out equals hsync_in from 3 cycles earlier.
REQ-027 Write wr_addr=3700 -> no buffer location changes; then read and write addr 5 in the same cycle -> the read returns the old word.
REQ-028 Assert rst=0 mid-line -> rgb=0 and sync outputs=0 at once; after release, previously written cells still render.
REQ-029 With TEXT_CURSOR_EN, cursor at (2,3) and 16 vsync rising edges -> cell (2,3) colours swap; after 32 edges -> normal colours return.
